// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states,
// Booth step opcodes and the decode helper used by the step unit.
// Optional build macro: BOOTH_EARLY_TERM_EN (see booth_seq_ctrl).
package booth_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth step operation selected by {Q[0], q_1}.
    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_e;

    // Default operand width and the step counter width that goes with it.
    // Modules with a different WIDTH derive their own counter width.
    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // 10 -> subtract M, 01 -> add M, 00/11 -> no arithmetic.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
        booth_op_e op;
        case ({q0, q_1})
            2'b10:   op = SUB;
            2'b01:   op = ADD;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step_unit.sv
// One radix-2 Booth step: optional add/sub of M into A, then an arithmetic
// right shift of {A, Q, q_1} by one. Purely combinational.
module booth_step_unit
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q1_in,
    input  logic [WIDTH:0]   m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q1_out
);

    booth_op_e      op;
    logic [WIDTH:0] sum;

    // Select the Booth operation, apply it to A, then shift the triple right.
    always_comb begin
        op  = booth_decode(q_in[0], q1_in);
        sum = a_in;
        case (op)
            ADD:     sum = a_in + m_in;
            SUB:     sum = a_in - m_in;
            default: sum = a_in;
        endcase
        a_out  = {sum[WIDTH], sum[WIDTH:1]};
        q_out  = {sum[0], q_in[WIDTH-1:1]};
        q1_out = q_in[0];
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-2 Booth multiplier controller. Operands arrive on a
// valid/ready input, the recurrence runs one step per cycle in RUN, and the
// signed product is held on a valid/ready output in DONE.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and its data steady until that edge.
//
// Optional build macro: BOOTH_EARLY_TERM_EN. When defined, a RUN cycle whose
// remaining multiplier bits (the unconsumed part of Q plus q_1) are all equal
// finishes the remaining pure-shift steps at once and moves to DONE.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    // A is one bit wider than the operands so that subtracting the most
    // negative multiplicand cannot overflow.
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       step_a;
    logic [WIDTH-1:0]     step_q;
    logic                 step_q1;

    booth_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_in   (a_q),
        .q_in   (q_q),
        .q1_in  (q1_q),
        .m_in   (m_q),
        .a_out  (step_a),
        .q_out  (step_q),
        .q1_out (step_q1)
    );

`ifdef BOOTH_EARLY_TERM_EN
    localparam logic [CW:0] W_CNT = (CW + 1)'(WIDTH);

    logic [WIDTH-1:0]           rem_mask;
    logic                       early_hit;
    logic [CW:0]                shamt;
    logic signed [2*WIDTH+1:0]  full_vec;
    logic signed [2*WIDTH+1:0]  sh_vec;

    // Detect an all-equal tail of unconsumed multiplier bits and form the
    // {A, Q, q_1} triple after all remaining shift-only steps.
    always_comb begin
        rem_mask  = {WIDTH{1'b1}} >> cnt_q;
        early_hit = q1_q ? ((q_q & rem_mask) == rem_mask)
                         : ((q_q & rem_mask) == '0);
        shamt     = W_CNT - {1'b0, cnt_q};
        full_vec  = {a_q, q_q, q1_q};
        sh_vec    = full_vec >>> shamt;
    end
`endif

    // Next-state, datapath loads and product capture.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = '0;
                    q_d     = a;
                    q1_d    = 1'b0;
                    m_d     = {b[WIDTH-1], b};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                q1_d  = step_q1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    product_d = {step_a[WIDTH-1:0], step_q};
                    state_d   = DONE;
                end
`ifdef BOOTH_EARLY_TERM_EN
                if (early_hit) begin
                    a_d       = sh_vec[2*WIDTH+1:WIDTH+1];
                    q_d       = sh_vec[WIDTH:1];
                    q1_d      = sh_vec[0];
                    product_d = sh_vec[2*WIDTH:1];
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        product   = product_q;
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH = 8): directed vector table,
// hand-written corner sequences and randomized streams against a plain
// arithmetic reference model.
module tb_booth_seq_ctrl;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] exp_q[$];
    logic [W-1:0]  src_a_q[$];
    logic [W-1:0]  src_b_q[$];

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    booth_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference product: plain signed multiplication truncated to 2*W bits.
    function automatic logic [PW-1:0] model_product(input logic [W-1:0] av, input logic [W-1:0] bv);
        int pa;
        int pb;
        pa = int'($signed(av));
        pb = int'($signed(bv));
        return PW'(pa * pb);
    endfunction

    // Expected number of RUN cycles (= edges from accept to out_valid).
    function automatic int exp_run_cycles(input logic [W-1:0] av);
        int   res;
        logic prev;
        bit   same;
        res = W;
`ifdef BOOTH_EARLY_TERM_EN
        // Step c looks at bits a[c] and a[c-1] (a[-1] = 0); once the tail
        // a[W-1:c] together with a[c-1] is uniform, the rest is shift only.
        for (int c = W - 1; c >= 0; c--) begin
            prev = (c == 0) ? 1'b0 : av[c-1];
            same = 1'b1;
            for (int i = c; i < W; i++) begin
                if (av[i] != prev) same = 1'b0;
            end
            if (same) res = c + 1;
        end
`else
        prev = av[0];
        same = 1'b0;
        if (prev === 1'bx && same) res = 0;
`endif
        return res;
    endfunction

    // Drive one operand pair from IDLE and wait for out_valid.
    task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv,
                           output logic [PW-1:0] p, output int lat);
        check("in_ready_before_accept", {15'd0, in_ready}, 16'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
        p = product;
    endtask

    // Stream the source queues through the DUT, holding in_valid high while
    // operands remain; out_ready is random or tied high.
    task automatic run_stream(input bit rand_ready, input string tag);
        int            cyc;
        logic          hs_in;
        logic          hs_out;
        logic          prev_stall;
        logic [PW-1:0] prev_prod;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_prod  = '0;
        if (src_a_q.size() > 0) begin
            a        = src_a_q[0];
            b        = src_b_q[0];
            in_valid = 1'b1;
        end
        while ((src_a_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #0;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (out_valid && prev_stall) begin
                check({tag, "_stall_stable"}, product, prev_prod);
            end
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_out"}, 16'd1, 16'd0);
                end else begin
                    check({tag, "_product"}, product, exp_q.pop_front());
                end
            end
            if (hs_in) begin
                exp_q.push_back(model_product(a, b));
                void'(src_a_q.pop_front());
                void'(src_b_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_prod  = product;
            step();
            cyc++;
            if (hs_in) begin
                if (src_a_q.size() > 0) begin
                    a = src_a_q[0];
                    b = src_b_q[0];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check({tag, "_timeout"}, {15'd0, (cyc >= 5000)}, 16'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        src_a_q.delete();
        src_b_q.delete();
        step();
    endtask

    initial begin
        logic [PW-1:0] p;
        int            lat;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        vecs[0] = '{8'h03, 8'hFC, 16'hFFF4};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{8'h07, 8'h09, 16'h003F};
        vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[5] = '{8'h05, 8'h06, 16'h001E};
        vecs[6] = '{8'hFE, 8'h03, 16'hFFFA};
        vecs[7] = '{8'h00, 8'hF9, 16'h0000};
        vecs[8] = '{8'h00, 8'h37, 16'h0000};
        vecs[9] = '{8'hFF, 8'h0A, 16'hFFF6};

        // Reset.
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        step();
        step();
        check("reset_in_ready", {15'd0, in_ready}, 16'd1);
        check("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_product", product, 16'd0);
        rst = 1'b0;
        step();

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].a, vecs[i].b, p, lat);
            check($sformatf("vec%0d_product", i), p, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), PW'(lat), PW'(exp_run_cycles(vecs[i].a)));
            step();
            check($sformatf("vec%0d_back_idle", i), {15'd0, in_ready}, 16'd1);
        end

        // Output backpressure: product and handshake stable while stalled.
        out_ready = 1'b0;
        run_one(8'h07, 8'h09, p, lat);
        check("stall_first_product", p, 16'h003F);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_out_valid", {15'd0, out_valid}, 16'd1);
            check("stall_product", product, 16'h003F);
            check("stall_in_ready", {15'd0, in_ready}, 16'd0);
        end
        out_ready = 1'b1;
        step();
        check("release_out_valid", {15'd0, out_valid}, 16'd0);
        check("release_in_ready", {15'd0, in_ready}, 16'd1);
        check("release_product_held", product, 16'h003F);

        // Reset during RUN discards the partial result.
        a        = 8'h05;
        b        = 8'h05;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("midrun_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("midrun_rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("midrun_rst_product", product, 16'd0);
        check("midrun_rst_busy", {15'd0, busy}, 16'd0);
        run_one(8'hFF, 8'hFF, p, lat);
        check("after_rst_product", p, 16'h0001);
        step();

        // Back-to-back stream with in_valid held high.
        src_a_q = '{8'h05, 8'hFE, 8'h00};
        src_b_q = '{8'h06, 8'h03, 8'hF9};
        run_stream(1'b0, "b2b");

        // Random single transactions with latency check.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) ra = (i % 10 == 0) ? 8'hFF : 8'h00;
            run_one(ra, rb, p, lat);
            check("rand_product", p, model_product(ra, rb));
            check("rand_latency", PW'(lat), PW'(exp_run_cycles(ra)));
            step();
        end

        // Random stream with random backpressure.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = 8'h80;
            if (i % 8 == 3) ra = 8'h80;
            src_a_q.push_back(ra);
            src_b_q.push_back(rb);
        end
        run_stream(1'b1, "rstream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
